ps2_command_tx: RTL and testbench
=================================

Name: ps2_command_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable).
- It is the outbound counterpart of the PS2 receive path. It shares the PS2_CLK/PS2_DAT open-drain lines through output-enable signals.
- The top level ties each line low when its enable is 1 and tri-states it otherwise.
- It reports completion, device ACK, or the failure cause to the game control logic.

Parameters:
- CLK_INHIBIT_CYCLES, 5000: CLOCK_50 cycles that PS2_CLK is held low before the request (100 us).
- REQ_SETUP_CYCLES, 500: cycles that DAT is held low with CLK still low, before CLK is released (10 us).
- START_TIMEOUT, 750000: maximum cycles from CLK release to the first device falling edge (15 ms).
- XFER_TIMEOUT, 100000: maximum cycles from the first falling edge to the ACK sample (2 ms).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- send_cmd  in  1  1-cycle request. Sampled only in IDLE.
- cmd_data  in  8  command byte. Latched on an accepted send_cmd.
- ps2_clk_in  in  1  raw PS2_CLK line level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT line level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- busy  out  1  high from the accept cycle until return to IDLE.
- cmd_sent  out  1  1-cycle pulse when the device ACK is received.
- tx_error  out  1  1-cycle pulse on a failure.
- error_code  out  2  cause of the last failure, held until the next accept. 00 none, 01 start timeout, 10 transfer timeout, 11 no ACK.

Behaviour:
- Reset values: all outputs 0. State IDLE, counters 0, both lines released.
- Reset asserted mid-transfer: lines are released on the next edge, no pulse is emitted, and error_code is cleared.
- Line inputs:
  - Each line passes through a 2-flop synchronizer.
  - A device falling edge (fe) is registered when the previous synchronized value was 1 and the current one is 0.
  - Total detect latency is 3 cycles max.
- IDLE: on send_cmd, latch cmd_data, compute parity = ~^cmd_data (odd parity), clear error_code, set busy, go to INHIBIT. send_cmd outside IDLE is ignored, not queued.
- INHIBIT: clk_oe=1, dat_oe=0. After CLK_INHIBIT_CYCLES cycles, go to REQ.
- REQ: clk_oe=1, dat_oe=1 (start bit). After REQ_SETUP_CYCLES cycles, go to WAIT_FIRST with clk_oe=0.
- WAIT_FIRST: dat_oe stays 1.
  - fe: bit index = 0, go to SHIFT, restart the counter.
  - Counter reaches START_TIMEOUT: code 01, go to FAIL.
- SHIFT:
  - On each fe, the host drives the next bit. fe #1..8 drive d0..d7 (LSB first), fe #9 drives parity, fe #10 drives stop (release).
  - dat_oe = ~bit. The value changes only in the cycle after the fe detect, never while CLK is high.
  - After fe #10, go to ACK.
- ACK:
  - On fe #11, sample synchronized DAT. 0: pulse cmd_sent, go to WAIT_IDLE. 1: code 11, go to FAIL.
- Timeout: XFER_TIMEOUT expiring at any point in SHIFT or ACK gives code 10 and goes to FAIL.
- WAIT_IDLE: both lines released. Wait until synchronized CLK and DAT are both 1, then go to IDLE and clear busy.
- FAIL: release both lines, pulse tx_error for 1 cycle, set error_code, go to WAIT_IDLE.
- Arithmetic and widths:
  - One shared down-counter, sized to the width of the largest parameter; 20 bits at the defaults.
  - Bit index is 4 bits, and fe counts saturate at 11.
- Other rules:
  - cmd_sent and tx_error are never asserted in the same cycle.
  - clk_oe and dat_oe are never both 1 except during REQ.
  - Device response bytes (0xFA etc.) are received by the existing PS2 receive path, not by this block.

Test Plan:
All cases run with CLK_INHIBIT_CYCLES=50, REQ_SETUP_CYCLES=10, START_TIMEOUT=2000, XFER_TIMEOUT=5000, against a device model clocking at a 200-cycle period.
- send_cmd with 0xED:
  - clk_oe must be high for exactly 50 cycles, then dat_oe must rise while clk_oe is still high for 10 cycles.
  - The device must sample 1,0,1,1,0,1,1,1 then parity 1 and stop 1. The device ACKs, and cmd_sent must pulse once.
  - busy must clear after both lines are high, and error_code must be 00.
- send_cmd with 0x00 (parity 1) and with 0x01 (parity 0): the sampled parity must match in each case, and the device model must flag no framing error.
- Device never clocks: tx_error must pulse 2000 cycles after CLK release, with error_code=01, both oe 0, then busy=0.
- Device holds DAT high at fe #11: tx_error must pulse with error_code=11, and cmd_sent must stay 0.
- Device stops clocking after fe #4: tx_error must pulse with error_code=10 within 5000 cycles of fe #1.
- Second send_cmd mid-transfer is ignored (the original byte completes unchanged).
- reset at fe #6: both oe must be 0 next cycle and busy=0; a subsequent 0xFF command must complete with cmd_sent.

Source files
------------

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte plus odd parity and stop out on the device clock, and checks the device ACK.
module ps2_command_tx #(
    parameter int CLK_INHIBIT_CYCLES = 5000,
    parameter int REQ_SETUP_CYCLES   = 500,
    parameter int START_TIMEOUT      = 750000,
    parameter int XFER_TIMEOUT       = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       send_cmd,
    input  logic [7:0] cmd_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       cmd_sent,
    output logic       tx_error,
    output logic [1:0] error_code
);

    localparam int MAX_A   = (CLK_INHIBIT_CYCLES > REQ_SETUP_CYCLES) ? CLK_INHIBIT_CYCLES : REQ_SETUP_CYCLES;
    localparam int MAX_B   = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(CLK_INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LOAD     = CNT_W'(REQ_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LOAD   = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LOAD    = CNT_W'(XFER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_INHIBIT    = 3'd1;
    localparam logic [2:0] ST_REQ        = 3'd2;
    localparam logic [2:0] ST_WAIT_FIRST = 3'd3;
    localparam logic [2:0] ST_SHIFT      = 3'd4;
    localparam logic [2:0] ST_ACK        = 3'd5;
    localparam logic [2:0] ST_WAIT_IDLE  = 3'd6;
    localparam logic [2:0] ST_FAIL       = 3'd7;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    logic       clk_meta_r, clk_sync_r, clk_prev_r;
    logic       dat_meta_r, dat_sync_r;
    logic       fe_s;
    logic [2:0] state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [9:0] frame_r;
    logic [3:0] fe_cnt_r;

    assign fe_s = clk_prev_r & ~clk_sync_r;

    // Two-flop synchronizers for both lines plus the delayed clock used for edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            clk_prev_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk_in;
            clk_sync_r <= clk_meta_r;
            clk_prev_r <= clk_sync_r;
            dat_meta_r <= ps2_dat_in;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Transmit sequencer; line enables and status flags are registered alongside the state.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            frame_r    <= 10'd0;
            fe_cnt_r   <= 4'd0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            cmd_sent   <= 1'b0;
            tx_error   <= 1'b0;
            error_code <= 2'b00;
        end else begin
            cmd_sent <= 1'b0;
            tx_error <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (send_cmd) begin
                        frame_r    <= {1'b1, odd_parity(cmd_data), cmd_data};
                        error_code <= 2'b00;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        ps2_dat_oe <= 1'b0;
                        cnt_r      <= INHIBIT_LOAD;
                        fe_cnt_r   <= 4'd0;
                        state_r    <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt_r == CNT_ZERO) begin
                        ps2_dat_oe <= 1'b1;
                        cnt_r      <= REQ_LOAD;
                        state_r    <= ST_REQ;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_REQ: begin
                    if (cnt_r == CNT_ZERO) begin
                        ps2_clk_oe <= 1'b0;
                        cnt_r      <= START_LOAD;
                        state_r    <= ST_WAIT_FIRST;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_WAIT_FIRST: begin
                    if (fe_s) begin
                        ps2_dat_oe <= ~frame_r[0];
                        frame_r    <= {1'b1, frame_r[9:1]};
                        fe_cnt_r   <= 4'd1;
                        cnt_r      <= XFER_LOAD;
                        state_r    <= ST_SHIFT;
                    end else if (cnt_r == CNT_ZERO) begin
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        error_code <= 2'b01;
                        state_r    <= ST_FAIL;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_SHIFT: begin
                    // The transfer timer keeps running across edges so it bounds the whole frame.
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                    if (fe_s) begin
                        ps2_dat_oe <= ~frame_r[0];
                        frame_r    <= {1'b1, frame_r[9:1]};
                        fe_cnt_r   <= fe_cnt_r + 4'd1;
                        if (fe_cnt_r == 4'd9) begin
                            state_r <= ST_ACK;
                        end
                    end else if (cnt_r == CNT_ZERO) begin
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        error_code <= 2'b10;
                        state_r    <= ST_FAIL;
                    end
                end
                ST_ACK: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                    if (fe_s) begin
                        fe_cnt_r <= 4'd11;
                        if (!dat_sync_r) begin
                            cmd_sent <= 1'b1;
                            state_r  <= ST_WAIT_IDLE;
                        end else begin
                            tx_error   <= 1'b1;
                            error_code <= 2'b11;
                            state_r    <= ST_FAIL;
                        end
                    end else if (cnt_r == CNT_ZERO) begin
                        tx_error   <= 1'b1;
                        error_code <= 2'b10;
                        state_r    <= ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state_r    <= ST_WAIT_IDLE;
                end
                ST_WAIT_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (clk_sync_r && dat_sync_r) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: a PS/2 device model clocks the host frame out and the sampled
// bits, pulses and timings are compared against a reference derived from the protocol rules.
module tb_ps2_command_tx;

    localparam int INH = 50;
    localparam int REQ = 10;
    localparam int STO = 2000;
    localparam int XTO = 5000;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       send_cmd = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       clk_line, dat_line;
    logic       ps2_clk_oe, ps2_dat_oe, busy, cmd_sent, tx_error;
    logic [1:0] error_code;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fe1_cyc = 0;
    int sent_n = 0, err_n = 0, both_pulse_n = 0, both_oe_n = 0;
    logic [9:0] smp;

    assign clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_command_tx #(
        .CLK_INHIBIT_CYCLES(INH),
        .REQ_SETUP_CYCLES  (REQ),
        .START_TIMEOUT     (STO),
        .XFER_TIMEOUT      (XTO)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .send_cmd  (send_cmd),
        .cmd_data  (cmd_data),
        .ps2_clk_in(clk_line),
        .ps2_dat_in(dat_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .cmd_sent  (cmd_sent),
        .tx_error  (tx_error),
        .error_code(error_code)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (cmd_sent === 1'b1) sent_n <= sent_n + 1;
        if (tx_error === 1'b1) err_n <= err_n + 1;
        if (cmd_sent === 1'b1 && tx_error === 1'b1) both_pulse_n <= both_pulse_n + 1;
        if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1) both_oe_n <= both_oe_n + 1;
    end

    // Expected 10-bit frame as the device sees it: d0..d7, odd parity, stop
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic start_cmd(input logic [7:0] b, output int inh, output int req, output logic st);
        @(negedge CLOCK_50);
        send_cmd = 1'b1;
        cmd_data = b;
        @(negedge CLOCK_50);
        send_cmd = 1'b0;
        cmd_data = 8'h00;
        inh = 0;
        while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && inh < 1000) begin
            inh++;
            @(negedge CLOCK_50);
        end
        req = 0;
        while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1 && req < 1000) begin
            req++;
            @(negedge CLOCK_50);
        end
        st = dat_line;
    endtask

    // Device clocking: nclk data clocks (200-cycle period), then ack_mode 1 = ACK low, 2 = DAT left high
    task automatic dev_clock(input int nclk, input int ack_mode, input bit inject);
        smp = 10'd0;
        repeat (300) @(negedge CLOCK_50);
        for (int k = 1; k <= nclk; k++) begin
            dev_clk_low = 1'b1;
            if (k == 1) fe1_cyc = cyc;
            repeat (100) @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            smp[k-1] = dat_line;
            if (inject && k == 3) begin
                send_cmd = 1'b1;
                cmd_data = 8'h5A;
                @(negedge CLOCK_50);
                send_cmd = 1'b0;
                repeat (99) @(negedge CLOCK_50);
            end else begin
                repeat (100) @(negedge CLOCK_50);
            end
        end
        if (ack_mode == 1) begin
            dev_dat_low = 1'b1;
            repeat (50) @(negedge CLOCK_50);
            dev_clk_low = 1'b1;
            repeat (100) @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            repeat (20) @(negedge CLOCK_50);
            dev_dat_low = 1'b0;
        end else if (ack_mode == 2) begin
            dev_clk_low = 1'b1;
            repeat (100) @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            repeat (20) @(negedge CLOCK_50);
        end
    endtask

    task automatic finish_idle(output int w);
        w = 0;
        while (busy !== 1'b0 && w < 2000) begin
            w++;
            @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        n_cmp++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, cmd_sent, tx_error, error_code} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {ps2_clk_oe, ps2_dat_oe, busy, cmd_sent, tx_error, error_code});
        end
        reset = 1'b0;
        repeat (5) @(negedge CLOCK_50);
    endtask

    task automatic test_transfer(input logic [7:0] b, input bit inject);
        int inh, req, w, s0, e0, o0, p0, hi;
        logic st;
        logic [9:0] exp_f;
        exp_f = ref_frame(b);
        s0 = sent_n; e0 = err_n; o0 = both_oe_n; p0 = both_pulse_n;
        start_cmd(b, inh, req, st);
        n_cmp++;
        if (inh != INH) begin n_bad++; $display("FAIL inhibit_len[%h]: got %0d expected %0d", b, inh, INH); end
        n_cmp++;
        if (req != REQ) begin n_bad++; $display("FAIL req_len[%h]: got %0d expected %0d", b, req, REQ); end
        n_cmp++;
        if (st !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL start_bit[%h]: got dat=%b busy=%b expected dat=0 busy=1", b, st, busy);
        end
        dev_clock(10, 1, inject);
        n_cmp++;
        if (smp !== exp_f) begin n_bad++; $display("FAIL frame[%h]: got %b expected %b", b, smp, exp_f); end
        n_cmp++;
        if (smp[8] !== exp_f[8] || smp[9] !== 1'b1) begin
            n_bad++; $display("FAIL parity_stop[%h]: got %b%b expected %b1", b, smp[8], smp[9], exp_f[8]);
        end
        finish_idle(w);
        n_cmp++;
        if (busy !== 1'b0 || clk_line !== 1'b1 || dat_line !== 1'b1) begin
            n_bad++; $display("FAIL idle[%h]: got busy=%b clk=%b dat=%b expected 0 1 1", b, busy, clk_line, dat_line);
        end
        n_cmp++;
        if (error_code !== 2'b00) begin n_bad++; $display("FAIL code_ok[%h]: got %b expected 00", b, error_code); end
        n_cmp++;
        if (sent_n - s0 != 1 || err_n - e0 != 0 || both_pulse_n - p0 != 0) begin
            n_bad++; $display("FAIL pulses[%h]: got sent=%0d err=%0d expected 1 0", b, sent_n - s0, err_n - e0);
        end
        n_cmp++;
        if (both_oe_n - o0 != REQ) begin
            n_bad++; $display("FAIL both_oe[%h]: got %0d expected %0d", b, both_oe_n - o0, REQ);
        end
        if (inject) begin
            hi = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge CLOCK_50);
                if (ps2_clk_oe === 1'b1 || busy === 1'b1) hi++;
            end
            n_cmp++;
            if (hi != 0) begin n_bad++; $display("FAIL no_queue: got %0d busy cycles expected 0", hi); end
        end
    endtask

    task automatic test_no_clock();
        int inh, req, n, w, s0, e0;
        logic st;
        s0 = sent_n; e0 = err_n;
        start_cmd(8'($urandom_range(255, 0)), inh, req, st);
        n = 0;
        while (tx_error !== 1'b1 && n < 3000) begin
            n++;
            @(negedge CLOCK_50);
        end
        n_cmp++;
        if (n != STO) begin n_bad++; $display("FAIL start_timeout: got %0d expected %0d", n, STO); end
        n_cmp++;
        if (error_code !== 2'b01 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            n_bad++; $display("FAIL start_code: got %b oe=%b%b expected 01 oe=00", error_code, ps2_clk_oe, ps2_dat_oe);
        end
        finish_idle(w);
        n_cmp++;
        if (busy !== 1'b0 || sent_n - s0 != 0 || err_n - e0 != 1) begin
            n_bad++; $display("FAIL start_end: got busy=%b sent=%0d err=%0d expected 0 0 1", busy, sent_n - s0, err_n - e0);
        end
    endtask

    task automatic test_nack();
        int inh, req, w, s0, e0;
        logic st;
        s0 = sent_n; e0 = err_n;
        start_cmd(8'hF4, inh, req, st);
        dev_clock(10, 2, 1'b0);
        finish_idle(w);
        n_cmp++;
        if (err_n - e0 != 1 || sent_n - s0 != 0) begin
            n_bad++; $display("FAIL nack_pulses: got err=%0d sent=%0d expected 1 0", err_n - e0, sent_n - s0);
        end
        n_cmp++;
        if (error_code !== 2'b11 || busy !== 1'b0) begin
            n_bad++; $display("FAIL nack_code: got %b busy=%b expected 11 busy=0", error_code, busy);
        end
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        n_cmp++;
        if (error_code !== 2'b00) begin n_bad++; $display("FAIL reset_code: got %b expected 00", error_code); end
        repeat (5) @(negedge CLOCK_50);
    endtask

    task automatic test_xfer_timeout();
        int inh, req, d, w, s0;
        logic st;
        s0 = sent_n;
        start_cmd(8'($urandom_range(255, 0)), inh, req, st);
        dev_clock(4, 0, 1'b0);
        while (tx_error !== 1'b1 && cyc - fe1_cyc < 7000) @(negedge CLOCK_50);
        d = cyc - fe1_cyc;
        n_cmp++;
        if (d < XTO || d > XTO + 3) begin
            n_bad++; $display("FAIL xfer_timeout: got %0d cycles expected %0d..%0d", d, XTO, XTO + 3);
        end
        n_cmp++;
        if (error_code !== 2'b10 || sent_n - s0 != 0) begin
            n_bad++; $display("FAIL xfer_code: got %b sent=%0d expected 10 sent=0", error_code, sent_n - s0);
        end
        finish_idle(w);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL xfer_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int inh, req, s0, e0;
        logic st;
        start_cmd(8'h3C, inh, req, st);
        dev_clock(5, 0, 1'b0);
        s0 = sent_n; e0 = err_n;
        dev_clk_low = 1'b1;
        repeat (6) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        n_cmp++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid: got oe=%b%b busy=%b expected 00 0", ps2_clk_oe, ps2_dat_oe, busy);
        end
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        n_cmp++;
        if (sent_n - s0 != 0 || err_n - e0 != 0) begin
            n_bad++; $display("FAIL reset_pulse: got sent=%0d err=%0d expected 0 0", sent_n - s0, err_n - e0);
        end
        test_transfer(8'hFF, 1'b0);
    endtask

    initial begin
        test_reset();
        test_transfer(8'hED, 1'b0);
        test_transfer(8'h00, 1'b0);
        test_transfer(8'h01, 1'b0);
        for (int i = 0; i < 4; i++) test_transfer(8'($urandom_range(255, 0)), 1'b0);
        test_transfer(8'($urandom_range(255, 0)), 1'b1);
        test_no_clock();
        test_nack();
        test_xfer_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
